data_memory_responder: RTL and testbench

- Off-chip data memory model: the responder end of the dcache controller's line-fill/write-back interface.
- Accepts one 256-bit line request at a time (read or write).
- Waits a fixed, parameterised latency.
- Completes the request with a single-cycle ack pulse; read data is returned in the same ack cycle.
- Sits at top level beside CPU, wired to mem_addr/mem_data/mem_enable/mem_write/mem_ack.

---
 rtl/data_memory_responder.sv | 114 +++++++++++
 tb/tb_data_memory_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - off-chip line memory model answering dcache fill/write-back requests
module data_memory_responder #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int IDX_W   = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  localparam logic [7:0] LAT = 8'(LATENCY);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   req_idx_q, req_idx_d;
  logic [255:0]       req_data_q, req_data_d;
  logic               req_write_q, req_write_d;
  logic               ack_q, ack_d;
  logic [255:0]       data_q, data_d;
  logic               mem_we;

  logic [255:0]       memory [0:DEPTH-1];

  // Line offset and the bits above the line index never reach the array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_idx_d   = req_idx_q;
    req_data_d  = req_data_q;
    req_write_d = req_write_q;
    ack_d       = 1'b0;
    data_d      = data_q;
    mem_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          req_idx_d   = addr_i[IDX_W+4:5];
          req_data_d  = data_i;
          req_write_d = write_i;
          cnt_d       = 8'd1;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAT) begin
          state_d = ACK;
          ack_d   = 1'b1;
          if (req_write_q) begin
            mem_we = 1'b1;
          end else begin
            data_d = memory[req_idx_q];
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      req_idx_q   <= '0;
      req_data_q  <= '0;
      req_write_q <= 1'b0;
      ack_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_idx_q   <= req_idx_d;
      req_data_q  <= req_data_d;
      req_write_q <= req_write_d;
      ack_q       <= ack_d;
      data_q      <= data_d;
    end
  end

  // Storage is deliberately not reset; a reset forces IDLE so no pending write can commit.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      memory[req_idx_q] <= req_data_q;
    end
  end

  assign ack_o  = ack_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - randomized and directed checks of data_memory_responder against a scheduling model
module tb_data_memory_responder;

  localparam int LAT = 10;

  logic         clk_i;
  logic         rst_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;

  data_memory_responder #(.LATENCY(LAT), .DEPTH(512), .IDX_W(9)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Model: a request accepted at edge e completes at edge e+LAT; the next one may be accepted from edge e+LAT+2.
  logic [255:0] m_mem [0:511];
  logic         exp_ack;
  logic [255:0] exp_data;
  bit           m_busy;
  int           edge_n;
  int           m_ack_at;
  int           m_free_at;
  int           m_idx;
  logic [255:0] m_wdata;
  bit           m_wr;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_busy    = 0;
      exp_ack   = 1'b0;
      exp_data  = '0;
      m_free_at = 0;
      edge_n    = 0;
    end else begin
      edge_n++;
      exp_ack = 1'b0;
      if (m_busy && edge_n == m_ack_at) begin
        exp_ack = 1'b1;
        if (m_wr) m_mem[m_idx] = m_wdata;
        else      exp_data = m_mem[m_idx];
        m_busy    = 0;
        m_free_at = edge_n + 2;
      end else if (!m_busy && edge_n >= m_free_at && enable_i === 1'b1) begin
        m_idx    = int'(addr_i[13:5]);
        m_wdata  = data_i;
        m_wr     = write_i;
        m_busy   = 1;
        m_ack_at = edge_n + LAT;
      end
    end
  end

  bit compare_on = 0;

  always @(negedge clk_i) begin
    if (compare_on && !rst_i) begin
      chk("ack_o", {255'd0, ack_o}, {255'd0, exp_ack});
      chk("data_o", data_o, exp_data);
    end
  end

  // Drive one request starting at a negedge; returns at the negedge where ack_o is seen.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [255:0] d,
                        input bit churn, input bit hold, output int lat, output int ack_cyc);
    bit got;
    enable_i = 1'b1;
    write_i  = wr;
    addr_i   = a;
    data_i   = d;
    lat      = 0;
    got      = 0;
    ack_cyc  = 0;
    for (int i = 0; i < 4 * LAT + 10; i++) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
      if (ack_o === 1'b1) begin
        got = 1;
        ack_cyc = cyc;
        break;
      end
      if (churn && i >= 2) begin
        addr_i  = $urandom;
        data_i  = rand256();
        write_i = $urandom_range(0, 1);
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack expected ack within %0d cycles", 4 * LAT + 10);
    end
    if (!hold) enable_i = 1'b0;
  endtask

  localparam logic [255:0] A5  = {32{8'hA5}};
  localparam logic [255:0] PAT = {16'h1234, {14{16'h5678}}, 16'hBEEF};
  localparam logic [255:0] W0  = {8{32'hC0FF_EE00}};

  initial begin
    int lat, c1, c2, gap;
    bit hold, prev_hold;
    logic [255:0] v, old5;
    logic [31:0] a;

    rst_i    = 1'b1;
    enable_i = 1'b0;
    write_i  = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    for (int i = 0; i < 512; i++) begin
      v = rand256();
      if (i == 3) v = A5;
      if (i == 0) v = W0;
      dut.memory[i] = v;
      m_mem[i]      = v;
    end
    repeat (3) @(negedge clk_i);
    chk("reset_ack", {255'd0, ack_o}, 256'd0);
    chk("reset_data", data_o, 256'd0);
    rst_i = 1'b0;
    compare_on = 1;
    @(negedge clk_i);

    do_req(1'b0, 32'h60, '0, 0, 0, lat, c1);
    chk("read_latency", 256'(lat - 1), 256'd10);
    chk("read_a5_data", data_o, A5);
    chk("model_a5", exp_data, A5);
    @(negedge clk_i);
    chk("ack_one_cycle", {255'd0, ack_o}, 256'd0);

    do_req(1'b1, 32'h0000_0400, PAT, 0, 0, lat, c1);
    chk("write_ack_data_held", data_o, A5);
    @(negedge clk_i);
    chk("write_committed", dut.memory[32], PAT);
    do_req(1'b0, 32'h0000_0400, '0, 0, 0, lat, c1);
    chk("read_after_write", data_o, PAT);
    @(negedge clk_i);

    do_req(1'b0, 32'h0000_401F, '0, 0, 0, lat, c1);
    chk("wrap_offset_read", data_o, W0);
    @(negedge clk_i);
    do_req(1'b0, 32'h0000_4000, '0, 0, 0, lat, c1);
    chk("wrap_read", data_o, W0);
    @(negedge clk_i);

    do_req(1'b0, 32'h60, '0, 0, 1, lat, c1);
    do_req(1'b0, 32'h0000_0400, '0, 0, 0, lat, c2);
    chk("b2b_ack_spacing", 256'(c2 - c1), 256'd12);
    chk("b2b_data", data_o, PAT);
    @(negedge clk_i);

    do_req(1'b1, 32'h0000_0060, rand256(), 1, 0, lat, c1);
    chk("churn_latency", 256'(lat - 1), 256'd10);
    @(negedge clk_i);
    do_req(1'b0, 32'h0000_0060, '0, 0, 0, lat, c1);
    chk("churn_serviced", data_o, m_mem[3]);
    @(negedge clk_i);

    old5     = m_mem[5];
    enable_i = 1'b1;
    write_i  = 1'b1;
    addr_i   = 32'h0000_00A0;
    data_i   = ~old5;
    repeat (4) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("midreset_ack", {255'd0, ack_o}, 256'd0);
    chk("midreset_data", data_o, 256'd0);
    enable_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("midreset_mem_untouched", dut.memory[5], old5);
    @(negedge clk_i);
    do_req(1'b0, 32'h0000_00A0, '0, 0, 0, lat, c1);
    chk("post_reset_read", data_o, old5);
    chk("post_reset_latency", 256'(lat - 1), 256'd10);

    prev_hold = 0;
    for (int t = 0; t < 60; t++) begin
      if (!prev_hold) begin
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk_i);
      end
      hold = ($urandom_range(0, 3) == 0);
      a = ($urandom & 32'hFFFF_C01F) | (32'($urandom_range(0, 7)) << 5);
      do_req(1'($urandom_range(0, 1)), a, rand256(), 1'($urandom_range(0, 1)), hold, lat, c1);
      prev_hold = hold;
    end
    enable_i = 1'b0;
    repeat (LAT + 5) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
